// File: rtl/integer_dispatch_pkg.sv
// Shared types for the integer dispatch stage: register/tag widths, the
// register alias table entry and the issue-queue entry format.
package integer_dispatch_pkg;

  localparam int N_ARCH_REGS    = 32;
  localparam int ARCH_IDX_WIDTH = $clog2(N_ARCH_REGS);
  localparam int ROB_ID_WIDTH   = 4;
  localparam int XLEN           = 32;
  localparam int PAYLOAD_WIDTH  = 72;

  typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [XLEN-1:0]           reg_data_t;
  typedef logic [ARCH_IDX_WIDTH-1:0] arch_reg_idx_t;
  typedef logic [PAYLOAD_WIDTH-1:0]  payload_t;

  // One alias-table slot: busy means the newest value lives in the ROB.
  typedef struct packed {
    logic    busy;
    rob_id_t rob_id;
  } rat_entry_t;

  // One renamed source operand as the issue queue sees it.
  typedef struct packed {
    logic      valid;
    rob_id_t   rob_id;
    logic      ready;
    reg_data_t data;
  } iiq_src_t;

  typedef struct packed {
    iiq_src_t src1;
    iiq_src_t src2;
    logic     dst_valid;
    rob_id_t  instr_rob_id;
    payload_t payload;
  } iiq_entry_t;

  localparam int IIQ_ENTRY_WIDTH = $bits(iiq_entry_t);

endpackage

// File: rtl/integer_dispatch_if.sv
// Ready/valid channel from the dispatcher into the integer issue queue.
interface integer_dispatch_if;
  import integer_dispatch_pkg::*;

  logic       valid;
  logic       ready;
  iiq_entry_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/int_rat.sv
// Integer register alias table: two combinational read ports, one rename
// write and one tag-qualified commit clear. A rename to the same register
// in the same cycle as its commit keeps the new mapping; flush drops every
// mapping back to the architectural file.
module int_rat
  import integer_dispatch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_aH,
  input  logic          flush,
  input  arch_reg_idx_t rd_idx1,
  input  arch_reg_idx_t rd_idx2,
  output rat_entry_t    rd_entry1,
  output rat_entry_t    rd_entry2,
  input  logic          ren_valid,
  input  arch_reg_idx_t ren_idx,
  input  rob_id_t       ren_rob_id,
  input  logic          commit_valid,
  input  arch_reg_idx_t commit_idx,
  input  rob_id_t       commit_rob_id
);

  rat_entry_t rat_r [N_ARCH_REGS];

  assign rd_entry1 = rat_r[rd_idx1];
  assign rd_entry2 = rat_r[rd_idx2];

  // Table update: flush clears all, otherwise rename beats a matching commit.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int i = 0; i < N_ARCH_REGS; i++) begin
        rat_r[i] <= '{busy: 1'b0, rob_id: {ROB_ID_WIDTH{1'b0}}};
      end
    end else if (flush) begin
      for (int i = 0; i < N_ARCH_REGS; i++) begin
        rat_r[i].busy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_ARCH_REGS; i++) begin
        if (ren_valid && (ren_idx == ARCH_IDX_WIDTH'(i))) begin
          rat_r[i] <= '{busy: 1'b1, rob_id: ren_rob_id};
        end else if (commit_valid && (commit_idx == ARCH_IDX_WIDTH'(i)) &&
                     (rat_r[i].rob_id == commit_rob_id)) begin
          rat_r[i].busy <= 1'b0;
        end else begin
          rat_r[i] <= rat_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/integer_dispatch.sv
// Integer dispatch: renames one decoded instruction per cycle through the
// alias table, allocates its ROB id and presents a complete issue-queue
// entry from an output register that keeps snooping result broadcasts
// while the queue stalls it.
// Optional build macro INT_DISPATCH_STALL_CNT_EN adds the saturating
// stall_cycles / rob_full_cycles performance counters.
module integer_dispatch
  import integer_dispatch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_aH,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic                     dec_src1_valid,
  input  logic                     dec_src2_valid,
  input  logic                     dec_dst_valid,
  input  arch_reg_idx_t            dec_src1_arch,
  input  arch_reg_idx_t            dec_src2_arch,
  input  arch_reg_idx_t            dec_dst_arch,
  input  payload_t                 dec_payload,
  input  reg_data_t                arf_rd_data1,
  input  reg_data_t                arf_rd_data2,
  input  logic                     rob_alloc_ready,
  input  rob_id_t                  rob_alloc_id,
  output logic                     rob_alloc_valid,
  output rob_id_t                  rob_rd_id1,
  output rob_id_t                  rob_rd_id2,
  input  logic                     rob_rd_done1,
  input  logic                     rob_rd_done2,
  input  reg_data_t                rob_rd_data1,
  input  reg_data_t                rob_rd_data2,
  input  logic                     alu_broadcast_valid,
  input  rob_id_t                  alu_broadcast_rob_id,
  input  reg_data_t                alu_broadcast_reg_data,
  input  logic                     ld_broadcast_valid,
  input  rob_id_t                  ld_broadcast_rob_id,
  input  reg_data_t                ld_broadcast_reg_data,
  input  logic                     commit_valid,
  input  arch_reg_idx_t            commit_arch,
  input  rob_id_t                  commit_rob_id,
`ifdef INT_DISPATCH_STALL_CNT_EN
  output logic [31:0]              stall_cycles,
  output logic [31:0]              rob_full_cycles,
`endif
  input  logic                     flush,
  integer_dispatch_if.master       dispatch
);

  localparam arch_reg_idx_t ARCH_ZERO = {ARCH_IDX_WIDTH{1'b0}};
  localparam rob_id_t       ROB_ZERO  = {ROB_ID_WIDTH{1'b0}};
  localparam reg_data_t     DATA_ZERO = {XLEN{1'b0}};

  logic       dispatch_valid_r;
  iiq_entry_t entry_r;
  logic       dispatch_valid_next_s;
  iiq_entry_t entry_next_s;
  logic       accept_s;
  logic       ren_valid_s;
  rat_entry_t rat_rd1_s;
  rat_entry_t rat_rd2_s;
  iiq_entry_t new_entry_s;

  // Resolve a source at accept: x0/unused, ARF, or ROB tag with wakeup
  // from the ALU broadcast first, then load broadcast, then ROB lookup.
  function automatic iiq_src_t resolve_src(
    input logic          used,
    input arch_reg_idx_t arch,
    input rat_entry_t    map,
    input reg_data_t     arf_data,
    input logic          rob_done,
    input reg_data_t     rob_data,
    input logic          alu_v,
    input rob_id_t       alu_id,
    input reg_data_t     alu_d,
    input logic          ld_v,
    input rob_id_t       ld_id,
    input reg_data_t     ld_d
  );
    iiq_src_t s;
    s.valid  = used;
    s.rob_id = ROB_ZERO;
    s.ready  = 1'b1;
    s.data   = DATA_ZERO;
    if (!used || (arch == ARCH_ZERO)) begin
      s.data = DATA_ZERO;
    end else if (!map.busy) begin
      s.data = arf_data;
    end else begin
      s.rob_id = map.rob_id;
      if (alu_v && (alu_id == map.rob_id)) begin
        s.data = alu_d;
      end else if (ld_v && (ld_id == map.rob_id)) begin
        s.data = ld_d;
      end else if (rob_done) begin
        s.data = rob_data;
      end else begin
        s.ready = 1'b0;
      end
    end
    return s;
  endfunction

  // Wake a held, still-waiting source from a matching broadcast.
  function automatic iiq_src_t snoop_src(
    input iiq_src_t  s,
    input logic      alu_v,
    input rob_id_t   alu_id,
    input reg_data_t alu_d,
    input logic      ld_v,
    input rob_id_t   ld_id,
    input reg_data_t ld_d
  );
    iiq_src_t r;
    r = s;
    if (s.valid && !s.ready && alu_v && (alu_id == s.rob_id)) begin
      r.ready = 1'b1;
      r.data  = alu_d;
    end else if (s.valid && !s.ready && ld_v && (ld_id == s.rob_id)) begin
      r.ready = 1'b1;
      r.data  = ld_d;
    end else begin
      r = s;
    end
    return r;
  endfunction

  assign dec_ready       = rob_alloc_ready && !flush && (!dispatch_valid_r || dispatch.ready);
  assign accept_s        = dec_valid && dec_ready;
  assign rob_alloc_valid = accept_s;
  assign ren_valid_s     = accept_s && dec_dst_valid && (dec_dst_arch != ARCH_ZERO);
  assign rob_rd_id1      = rat_rd1_s.rob_id;
  assign rob_rd_id2      = rat_rd2_s.rob_id;

  int_rat u_rat (
    .clk           (clk),
    .rst_aH        (rst_aH),
    .flush         (flush),
    .rd_idx1       (dec_src1_arch),
    .rd_idx2       (dec_src2_arch),
    .rd_entry1     (rat_rd1_s),
    .rd_entry2     (rat_rd2_s),
    .ren_valid     (ren_valid_s),
    .ren_idx       (dec_dst_arch),
    .ren_rob_id    (rob_alloc_id),
    .commit_valid  (commit_valid),
    .commit_idx    (commit_arch),
    .commit_rob_id (commit_rob_id)
  );

  // Assemble the entry for the instruction being accepted this cycle.
  always_comb begin
    new_entry_s.src1 = resolve_src(dec_src1_valid, dec_src1_arch, rat_rd1_s, arf_rd_data1,
                                   rob_rd_done1, rob_rd_data1,
                                   alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                   ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
    new_entry_s.src2 = resolve_src(dec_src2_valid, dec_src2_arch, rat_rd2_s, arf_rd_data2,
                                   rob_rd_done2, rob_rd_data2,
                                   alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                   ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
    new_entry_s.dst_valid    = dec_dst_valid;
    new_entry_s.instr_rob_id = rob_alloc_id;
    new_entry_s.payload      = dec_payload;
  end

  // Output register next state: flush, load, hand-off, or snoop while stalled.
  always_comb begin
    dispatch_valid_next_s = dispatch_valid_r;
    entry_next_s          = entry_r;
    if (flush) begin
      dispatch_valid_next_s = 1'b0;
      entry_next_s          = {IIQ_ENTRY_WIDTH{1'b0}};
    end else if (accept_s) begin
      dispatch_valid_next_s = 1'b1;
      entry_next_s          = new_entry_s;
    end else if (dispatch_valid_r && dispatch.ready) begin
      dispatch_valid_next_s = 1'b0;
    end else if (dispatch_valid_r) begin
      entry_next_s.src1 = snoop_src(entry_r.src1,
                                    alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                    ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
      entry_next_s.src2 = snoop_src(entry_r.src2,
                                    alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                    ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
    end else begin
      dispatch_valid_next_s = 1'b0;
    end
  end

  // Output register holding the entry until the issue queue takes it.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      dispatch_valid_r <= 1'b0;
      entry_r          <= {IIQ_ENTRY_WIDTH{1'b0}};
    end else begin
      dispatch_valid_r <= dispatch_valid_next_s;
      entry_r          <= entry_next_s;
    end
  end

  assign dispatch.valid = dispatch_valid_r;
  assign dispatch.data  = entry_r;

`ifdef INT_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] rob_full_cnt_r;

  // Saturating performance counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      stall_cnt_r    <= 32'd0;
      rob_full_cnt_r <= 32'd0;
    end else begin
      if (dispatch_valid_r && !dispatch.ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (dec_valid && !rob_alloc_ready && (rob_full_cnt_r != 32'hFFFF_FFFF)) begin
        rob_full_cnt_r <= rob_full_cnt_r + 32'd1;
      end else begin
        rob_full_cnt_r <= rob_full_cnt_r;
      end
    end
  end

  assign stall_cycles    = stall_cnt_r;
  assign rob_full_cycles = rob_full_cnt_r;
`endif

endmodule

// File: tb/tb_integer_dispatch.sv
// Directed bench for integer_dispatch: rename, wakeup capture, held-entry
// snoop, commit tag races and flush, with hand-computed expectations.
module tb_integer_dispatch;
  import integer_dispatch_pkg::*;

  logic          clk = 1'b0;
  logic          rst_aH;
  logic          dec_valid, dec_ready;
  logic          dec_src1_valid, dec_src2_valid, dec_dst_valid;
  arch_reg_idx_t dec_src1_arch, dec_src2_arch, dec_dst_arch;
  payload_t      dec_payload;
  reg_data_t     arf_rd_data1, arf_rd_data2;
  logic          rob_alloc_ready, rob_alloc_valid;
  rob_id_t       rob_alloc_id, rob_rd_id1, rob_rd_id2;
  logic          rob_rd_done1, rob_rd_done2;
  reg_data_t     rob_rd_data1, rob_rd_data2;
  logic          alu_broadcast_valid, ld_broadcast_valid;
  rob_id_t       alu_broadcast_rob_id, ld_broadcast_rob_id;
  reg_data_t     alu_broadcast_reg_data, ld_broadcast_reg_data;
  logic          commit_valid;
  arch_reg_idx_t commit_arch;
  rob_id_t       commit_rob_id;
  logic          flush;
`ifdef INT_DISPATCH_STALL_CNT_EN
  logic [31:0]   stall_cycles, rob_full_cycles;
`endif

  integer_dispatch_if dif ();

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  integer_dispatch dut (
    .clk                    (clk),
    .rst_aH                 (rst_aH),
    .dec_valid              (dec_valid),
    .dec_ready              (dec_ready),
    .dec_src1_valid         (dec_src1_valid),
    .dec_src2_valid         (dec_src2_valid),
    .dec_dst_valid          (dec_dst_valid),
    .dec_src1_arch          (dec_src1_arch),
    .dec_src2_arch          (dec_src2_arch),
    .dec_dst_arch           (dec_dst_arch),
    .dec_payload            (dec_payload),
    .arf_rd_data1           (arf_rd_data1),
    .arf_rd_data2           (arf_rd_data2),
    .rob_alloc_ready        (rob_alloc_ready),
    .rob_alloc_id           (rob_alloc_id),
    .rob_alloc_valid        (rob_alloc_valid),
    .rob_rd_id1             (rob_rd_id1),
    .rob_rd_id2             (rob_rd_id2),
    .rob_rd_done1           (rob_rd_done1),
    .rob_rd_done2           (rob_rd_done2),
    .rob_rd_data1           (rob_rd_data1),
    .rob_rd_data2           (rob_rd_data2),
    .alu_broadcast_valid    (alu_broadcast_valid),
    .alu_broadcast_rob_id   (alu_broadcast_rob_id),
    .alu_broadcast_reg_data (alu_broadcast_reg_data),
    .ld_broadcast_valid     (ld_broadcast_valid),
    .ld_broadcast_rob_id    (ld_broadcast_rob_id),
    .ld_broadcast_reg_data  (ld_broadcast_reg_data),
    .commit_valid           (commit_valid),
    .commit_arch            (commit_arch),
    .commit_rob_id          (commit_rob_id),
`ifdef INT_DISPATCH_STALL_CNT_EN
    .stall_cycles           (stall_cycles),
    .rob_full_cycles        (rob_full_cycles),
`endif
    .flush                  (flush),
    .dispatch               (dif.master)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_src1_valid = 1'b0; dec_src2_valid = 1'b0; dec_dst_valid = 1'b0;
    dec_src1_arch = 5'd0; dec_src2_arch = 5'd0; dec_dst_arch = 5'd0;
    dec_payload = 72'd0; arf_rd_data1 = 32'd0; arf_rd_data2 = 32'd0;
    rob_alloc_id = 4'd0; rob_rd_done1 = 1'b0; rob_rd_done2 = 1'b0;
    rob_rd_data1 = 32'd0; rob_rd_data2 = 32'd0;
    alu_broadcast_valid = 1'b0; alu_broadcast_rob_id = 4'd0; alu_broadcast_reg_data = 32'd0;
    ld_broadcast_valid = 1'b0; ld_broadcast_rob_id = 4'd0; ld_broadcast_reg_data = 32'd0;
    commit_valid = 1'b0; commit_arch = 5'd0; commit_rob_id = 4'd0; flush = 1'b0;
  endtask

  task automatic issue(input logic s1v, input logic [4:0] s1, input logic s2v, input logic [4:0] s2,
                       input logic dv, input logic [4:0] d, input logic [3:0] id);
    dec_valid = 1'b1;
    dec_src1_valid = s1v; dec_src1_arch = s1;
    dec_src2_valid = s2v; dec_src2_arch = s2;
    dec_dst_valid = dv; dec_dst_arch = d;
    rob_alloc_id = id;
  endtask

  initial begin
    rst_aH = 1'b1;
    idle();
    dif.ready = 1'b1;
    rob_alloc_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 160'(dif.valid), 160'd0);
    chk("rst_data", 160'(dif.data), 160'd0);
    chk("rst_alloc", 160'(rob_alloc_valid), 160'd0);
    rst_aH = 1'b0;
    #2;
    chk("post_rst_dec_ready", 160'(dec_ready), 160'd1);

    // Independent op x5, x6 with idle RAT.
    issue(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 4'd3);
    arf_rd_data1 = 32'h11; arf_rd_data2 = 32'h22;
    dec_payload = 72'h12_3456_789A_BCDE_F012;
    #2;
    chk("ind_alloc_valid", 160'(rob_alloc_valid), 160'd1);
    tick(); idle(); #2;
    chk("ind_valid", 160'(dif.valid), 160'd1);
    chk("ind_s1_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("ind_s1_data", 160'(dif.data.src1.data), 160'h11);
    chk("ind_s2_ready", 160'(dif.data.src2.ready), 160'd1);
    chk("ind_s2_data", 160'(dif.data.src2.data), 160'h22);
    chk("ind_rob_id", 160'(dif.data.instr_rob_id), 160'd3);
    chk("ind_payload", 160'(dif.data.payload), 160'h12_3456_789A_BCDE_F012);
    chk("ind_alloc_idle", 160'(rob_alloc_valid), 160'd0);

    // Op A: x0 source, rename x5 -> id 3.
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'd3);
    arf_rd_data1 = 32'hFF;
    tick(); idle(); #2;
    chk("x0_s1_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("x0_s1_data", 160'(dif.data.src1.data), 160'd0);
    chk("a_dst_valid", 160'(dif.data.dst_valid), 160'd1);

    // Op B: RAW on x5, nothing completed.
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd4);
    arf_rd_data1 = 32'hEE;
    #2;
    chk("raw_rd_id", 160'(rob_rd_id1), 160'd3);
    tick(); idle(); #2;
    chk("raw_ready", 160'(dif.data.src1.ready), 160'd0);
    chk("raw_tag", 160'(dif.data.src1.rob_id), 160'd3);
    chk("raw_data", 160'(dif.data.src1.data), 160'd0);
    chk("raw_s2_ready", 160'(dif.data.src2.ready), 160'd1);

    // Op C: same-cycle ALU and load broadcast, ALU wins.
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd5);
    alu_broadcast_valid = 1'b1; alu_broadcast_rob_id = 4'd3; alu_broadcast_reg_data = 32'hAB;
    ld_broadcast_valid = 1'b1; ld_broadcast_rob_id = 4'd3; ld_broadcast_reg_data = 32'h77;
    tick(); idle(); #2;
    chk("cap_alu_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("cap_alu_data", 160'(dif.data.src1.data), 160'hAB);

    // Op D: load broadcast beats ROB completion on both sources.
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 4'd10);
    ld_broadcast_valid = 1'b1; ld_broadcast_rob_id = 4'd3; ld_broadcast_reg_data = 32'h77;
    rob_rd_done1 = 1'b1; rob_rd_data1 = 32'h99; rob_rd_done2 = 1'b1; rob_rd_data2 = 32'h98;
    tick(); idle(); #2;
    chk("cap_ld_s1", 160'(dif.data.src1.data), 160'h77);
    chk("cap_ld_s2", 160'(dif.data.src2.data), 160'h77);

    // Op E: ROB completion only on source 1.
    issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 4'd11);
    rob_rd_done1 = 1'b1; rob_rd_data1 = 32'h99;
    tick(); idle(); #2;
    chk("rob_s1_data", 160'(dif.data.src1.data), 160'h99);
    chk("rob_s1_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("rob_s2_ready", 160'(dif.data.src2.ready), 160'd0);
    chk("rob_s2_tag", 160'(dif.data.src2.rob_id), 160'd3);

    // Held snoop: entry id 6 waits on tag 3, stalled for three cycles.
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd6);
    tick(); idle(); dif.ready = 1'b0; #2;
    chk("hold_valid", 160'(dif.valid), 160'd1);
    chk("hold_s1_wait", 160'(dif.data.src1.ready), 160'd0);
    chk("hold_dec_ready", 160'(dec_ready), 160'd0);
    tick();
    ld_broadcast_valid = 1'b1; ld_broadcast_rob_id = 4'd3; ld_broadcast_reg_data = 32'h55;
    #2;
    chk("hold_pre_snoop", 160'(dif.data.src1.ready), 160'd0);
    tick(); idle(); #2;
    chk("snoop_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("snoop_data", 160'(dif.data.src1.data), 160'h55);
    chk("snoop_tag", 160'(dif.data.src1.rob_id), 160'd3);
    chk("snoop_rob_id", 160'(dif.data.instr_rob_id), 160'd6);
    chk("snoop_valid", 160'(dif.valid), 160'd1);
    tick(); dif.ready = 1'b1; #2;
    chk("snoop_held_data", 160'(dif.data.src1.data), 160'h55);
    tick(); #2;
    chk("handoff_valid", 160'(dif.valid), 160'd0);

    // Commit race: rename x5 -> 7 while committing x5/3.
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'd7);
    commit_valid = 1'b1; commit_arch = 5'd5; commit_rob_id = 4'd3;
    tick(); idle();
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd8);
    #2;
    chk("race_rd_id", 160'(rob_rd_id1), 160'd7);
    tick(); idle(); #2;
    chk("race_ready", 160'(dif.data.src1.ready), 160'd0);
    chk("race_tag", 160'(dif.data.src1.rob_id), 160'd7);

    // Stale commit x5/3 leaves the id 7 mapping busy.
    commit_valid = 1'b1; commit_arch = 5'd5; commit_rob_id = 4'd3;
    tick(); idle();
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd12);
    arf_rd_data1 = 32'h33;
    tick(); idle(); #2;
    chk("stale_ready", 160'(dif.data.src1.ready), 160'd0);
    chk("stale_tag", 160'(dif.data.src1.rob_id), 160'd7);

    // Matching commit x5/7 frees x5 back to the ARF.
    commit_valid = 1'b1; commit_arch = 5'd5; commit_rob_id = 4'd7;
    tick(); idle();
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd13);
    arf_rd_data1 = 32'h44;
    tick(); idle(); #2;
    chk("commit_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("commit_data", 160'(dif.data.src1.data), 160'h44);

    // Flush with x5 busy (id 14) and an entry held.
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 4'd14);
    arf_rd_data1 = 32'h44;
    tick(); idle(); dif.ready = 1'b0;
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd9);
    flush = 1'b1;
    #2;
    chk("flush_dec_ready", 160'(dec_ready), 160'd0);
    chk("flush_alloc", 160'(rob_alloc_valid), 160'd0);
    tick(); idle(); #2;
    chk("flush_valid", 160'(dif.valid), 160'd0);
    chk("flush_data", 160'(dif.data), 160'd0);
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 4'd15);
    arf_rd_data1 = 32'h5A5A;
    #2;
    chk("post_flush_dec_ready", 160'(dec_ready), 160'd1);
    tick(); idle(); #2;
    chk("post_flush_ready", 160'(dif.data.src1.ready), 160'd1);
    chk("post_flush_data", 160'(dif.data.src1.data), 160'h5A5A);
    chk("post_flush_valid", 160'(dif.valid), 160'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_dispatch.md
Name: integer_dispatch

Overview:
- Producer side of the integer issue queue's dispatch ready/valid interface.
- Takes one decoded integer instruction per cycle and renames its sources through an internal register alias table (RAT) to an architectural value or a ROB tag.
- Allocates a ROB id and builds a complete IIQ entry, including source ready bits and captured data.
- Holds the entry in a snooping output register until the issue queue accepts it.

Parameters:
- N_ARCH_REGS, 32, architectural integer registers; index width is clog2 of this.
- ROB_ID_WIDTH, 4, ROB tag width.
- XLEN, 32, register data width.
- PAYLOAD_WIDTH, 72, opaque bits passed straight through (imm, pc, alu ctrl, branch predictions).

Ports:
- clk  in  1  clock.
- rst_aH  in  1  asynchronous active-high reset.
- dec_valid  in  1  decoded instruction valid.
- dec_ready  out  1  dispatcher accepts this cycle.
- dec_src1_valid, dec_src2_valid, dec_dst_valid  in  1 each  operand used.
- dec_src1_arch, dec_src2_arch, dec_dst_arch  in  5 each  architectural register index.
- dec_payload  in  PAYLOAD_WIDTH  pass-through.
- arf_rd_data1, arf_rd_data2  in  XLEN each  combinational ARF read, indexed by dec_srcN_arch.
- rob_alloc_ready  in  1  ROB has a free slot.
- rob_alloc_id  in  ROB_ID_WIDTH  ROB tail id.
- rob_alloc_valid  out  1  pulses on accept.
- rob_rd_id1, rob_rd_id2  out  ROB_ID_WIDTH each  ROB lookup tag.
- rob_rd_done1, rob_rd_done2  in  1 each  tag has completed.
- rob_rd_data1, rob_rd_data2  in  XLEN each  completed value.
- alu_broadcast_valid  in  1  ALU result broadcast valid.
- alu_broadcast_rob_id  in  ROB_ID_WIDTH  ALU broadcast tag.
- alu_broadcast_reg_data  in  XLEN  ALU broadcast value.
- ld_broadcast_valid  in  1  load result broadcast valid.
- ld_broadcast_rob_id  in  ROB_ID_WIDTH  load broadcast tag.
- ld_broadcast_reg_data  in  XLEN  load broadcast value.
- commit_valid  in  1  ROB head retires.
- commit_arch  in  5  retiring destination register.
- commit_rob_id  in  ROB_ID_WIDTH  retiring tag.
- flush  in  1  pipeline flush.
- dispatch_valid  out  1  entry valid to IIQ.
- dispatch_ready  in  1  IIQ accepts.
- dispatch_data  out  IIQ entry width  {srcN_valid, srcN_rob_id, srcN_ready, srcN_data, dst_valid, instr_rob_id, payload}.

Behaviour:
- Reset (async, rst_aH=1):
  - all RAT busy bits 0; output register empty.
  - dispatch_valid=0, rob_alloc_valid=0, dispatch_data=0.
  - dec_ready is combinational, so it follows the accept equation once reset releases.
- Reset mid-operation discards the held entry with no ROB side effect; the allocated ROB slot is the ROB's to reclaim on its own reset.
- accept = dec_valid && rob_alloc_ready && !flush && (!dispatch_valid || dispatch_ready).
  - dec_ready equals accept without the dec_valid term.
  - rob_alloc_valid = accept (combinational).
- Latency: an entry accepted in cycle N appears on dispatch_data with dispatch_valid=1 in cycle N+1.
- Back-to-back accepts with dispatch_ready=1 give full throughput.
- Source resolution at accept, per source:
  - src invalid or arch==0: ready=1, data=0.
  - RAT[arch] not busy: ready=1, data=arf_rd_dataN.
  - busy: rob_id=RAT tag; rob_rd_idN=RAT tag.
  - Busy with a tag match: if rob_rd_doneN, or a valid ALU/load broadcast matches the tag, then ready=1 and data is taken from the ROB or the broadcast. Priority: ALU, then load, then ROB.
  - Busy with no match: ready=0, data=0.
- Sources read the RAT before the same instruction's rename, so src==dst sees the old mapping.
- Rename at accept: if dst_valid && dst_arch!=0, RAT[dst]={busy=1, rob_alloc_id}; instr_rob_id=rob_alloc_id.
- Commit: clear busy of RAT[commit_arch] only if its tag equals commit_rob_id.
  - If the same register is renamed in the same cycle, the rename wins.
- Held entry snoop:
  - While dispatch_valid && !dispatch_ready, each not-ready valid source compares against both broadcasts each cycle.
  - On a match it sets ready=1 and captures data, with ALU priority over load.
  - This closes the wakeup-loss window.
- Flush:
  - clears all busy bits and the output register next edge; dispatch_valid=0 next cycle.
  - accept is suppressed during flush.
  - Flush overrides commit and rename.
- Stall: dispatch_data is held stable while valid and not ready; only the snoop fields may change.

Optional Feature:
- Macro INT_DISPATCH_STALL_CNT_EN.
- Defined: adds outputs stall_cycles and rob_full_cycles, each 32 bits.
  - stall_cycles increments when dispatch_valid && !dispatch_ready.
  - rob_full_cycles increments when dec_valid && !rob_alloc_ready.
  - Both saturate at all-ones, reset to 0, and are not cleared by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds: rob_id_t, reg_data_t, arch_reg_idx_t, iiq_entry_t (with the payload fields), rat_entry_t {busy, rob_id}.
- One sub-module, int_rat:
  - 32 entries with 2 combinational read ports, 1 rename write and 1 conditional commit clear.
  - Flush clear; rename-over-commit priority resolved internally.
- Source resolve and snoop muxes stay in the top level.

Test Plan:
- Independent op: dec src1=x5, src2=x6 with RAT idle, ARF values 0x11/0x22, rob_alloc_id=3 -> next cycle dispatch_valid=1, both ready=1, data 0x11/0x22, instr_rob_id=3.
- RAW chain: op A dst x5 at id 3, then op B src1=x5, rob_rd_done1=0, no broadcast -> B src1_ready=0, src1_rob_id=3.
- Same-cycle capture: as above but alu_broadcast_valid=1 for id 3 with data 0xAB during B's accept -> src1_ready=1, data 0xAB.
- Held snoop: dispatch_ready=0 for 3 cycles holding B; ld_broadcast for id 3 with 0x55 in cycle 2 -> src1 becomes ready with 0x55; entry stable otherwise; accepted when dispatch_ready rises.
- Commit race: commit x5/id 3 in the same cycle a new x5 rename to id 7 -> RAT[x5]={1,7}.
- Commit with stale tag: commit x5/id 3 after x5 was renamed to id 7 -> busy stays set.
- Flush: flush asserted with an entry held and x5 busy -> next cycle dispatch_valid=0, a following read of x5 resolves from ARF with ready=1.
